// File: rtl/pipe_pkg.sv
// Shared pipeline types for the ID->EX stage: default widths, EXE command
// encodings, the default-width ID/EX payload bundle and the skid FSM states.
package pipe_pkg;

  localparam int PIPE_DATA_W  = 32;
  localparam int PIPE_RADDR_W = 5;
  localparam int PIPE_CMD_W   = 4;

  localparam logic [PIPE_CMD_W-1:0] EXE_ADD = 4'd0;
  localparam logic [PIPE_CMD_W-1:0] EXE_SUB = 4'd1;
  localparam logic [PIPE_CMD_W-1:0] EXE_AND = 4'd2;
  localparam logic [PIPE_CMD_W-1:0] EXE_OR  = 4'd3;
  localparam logic [PIPE_CMD_W-1:0] EXE_XOR = 4'd4;
  localparam logic [PIPE_CMD_W-1:0] EXE_SLL = 4'd5;
  localparam logic [PIPE_CMD_W-1:0] EXE_SRL = 4'd6;
  localparam logic [PIPE_CMD_W-1:0] EXE_SRA = 4'd7;
  localparam logic [PIPE_CMD_W-1:0] EXE_SLT = 4'd8;
  localparam logic [PIPE_CMD_W-1:0] EXE_MOV = 4'd9;
  localparam logic [PIPE_CMD_W-1:0] EXE_NOP = 4'd15;

  typedef struct packed {
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    wb_en;
    logic [PIPE_CMD_W-1:0]   exe_cmd;
    logic [PIPE_RADDR_W-1:0] dest;
    logic [PIPE_RADDR_W-1:0] src1;
    logic [PIPE_RADDR_W-1:0] src2;
    logic [PIPE_DATA_W-1:0]  val1;
    logic [PIPE_DATA_W-1:0]  val2;
    logic [PIPE_DATA_W-1:0]  st_value;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer on a flat W-bit payload with flush.
// Ports: i_clk, i_rst (sync, high), i_flush, i_in_valid/o_in_ready/i_in_data,
// o_out_valid/i_out_ready/o_out_data. SKID=1: 2 entries, registered ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter bit SKID = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [W-1:0] i_in_data,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [W-1:0] o_out_data
);

  logic w_acc;
  logic w_drn;

  assign w_acc = i_in_valid & o_in_ready;
  assign w_drn = o_out_valid & i_out_ready;

  if (SKID) begin : g_skid
    skid_state_e  r_state;
    skid_state_e  w_state_nxt;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_ld_main;
    logic         w_ld_skid;
    logic         w_from_skid;

    always_comb begin
      w_state_nxt = r_state;
      w_ld_main   = 1'b0;
      w_ld_skid   = 1'b0;
      w_from_skid = 1'b0;
      unique case (r_state)
        ST_EMPTY: begin
          if (w_acc) begin
            w_state_nxt = ST_ONE;
            w_ld_main   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_acc && w_drn) begin
            w_ld_main = 1'b1;
          end else if (w_acc) begin
            w_state_nxt = ST_FULL;
            w_ld_skid   = 1'b1;
          end else if (w_drn) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drn) begin
            w_state_nxt = ST_ONE;
            w_ld_main   = 1'b1;
            w_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush kills both entries; payload regs keep their old data.
      if (i_flush) begin
        w_state_nxt = ST_EMPTY;
        w_ld_main   = 1'b0;
        w_ld_skid   = 1'b0;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state <= ST_EMPTY;
        r_main  <= '0;
        r_skid  <= '0;
      end else begin
        r_state <= w_state_nxt;
        if (w_ld_main) begin
          r_main <= w_from_skid ? r_skid : i_in_data;
        end
        if (w_ld_skid) begin
          r_skid <= i_in_data;
        end
      end
    end

    // Ready decodes only the state flop: no path from i_out_ready.
    assign o_in_ready  = (r_state != ST_FULL);
    assign o_out_valid = (r_state != ST_EMPTY);
    assign o_out_data  = r_main;
  end else begin : g_single
    logic         r_valid;
    logic [W-1:0] r_main;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end else if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_acc) begin
        r_valid <= 1'b1;
        r_main  <= i_in_data;
      end else if (w_drn) begin
        r_valid <= 1'b0;
      end
    end

    assign o_in_ready  = ~r_valid | i_out_ready;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_main;
  end

endmodule

// File: rtl/id_ex_stage_skid.sv
// ID->EX stage register: packs the decode payload into a skid buffer,
// gates control bits with valid, and counts bubble cycles (saturating).
module id_ex_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W  = PIPE_DATA_W,
  parameter int RADDR_W = PIPE_RADDR_W,
  parameter int CMD_W   = PIPE_CMD_W,
  parameter bit SKID    = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mem_r_en,
  input  logic               in_mem_w_en,
  input  logic               in_wb_en,
  input  logic [CMD_W-1:0]   in_exe_cmd,
  input  logic [RADDR_W-1:0] in_dest,
  input  logic [RADDR_W-1:0] in_src1,
  input  logic [RADDR_W-1:0] in_src2,
  input  logic [DATA_W-1:0]  in_val1,
  input  logic [DATA_W-1:0]  in_val2,
  input  logic [DATA_W-1:0]  in_st_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mem_r_en,
  output logic               out_mem_w_en,
  output logic               out_wb_en,
  output logic [CMD_W-1:0]   out_exe_cmd,
  output logic [RADDR_W-1:0] out_dest,
  output logic [RADDR_W-1:0] out_src1,
  output logic [RADDR_W-1:0] out_src2,
  output logic [DATA_W-1:0]  out_val1,
  output logic [DATA_W-1:0]  out_val2,
  output logic [DATA_W-1:0]  out_st_value,
  output logic [CNT_W-1:0]   bubble_cnt
);

  // Same layout as id_ex_payload_t, but sized by this instance's params.
  typedef struct packed {
    logic               mem_r_en;
    logic               mem_w_en;
    logic               wb_en;
    logic [CMD_W-1:0]   exe_cmd;
    logic [RADDR_W-1:0] dest;
    logic [RADDR_W-1:0] src1;
    logic [RADDR_W-1:0] src2;
    logic [DATA_W-1:0]  val1;
    logic [DATA_W-1:0]  val2;
    logic [DATA_W-1:0]  st_value;
  } payload_t;

  localparam int PW = $bits(payload_t);

  payload_t         w_in_pl;
  payload_t         w_out_pl;
  logic [PW-1:0]    w_out_flat;
  logic             w_out_valid;
  logic [CNT_W-1:0] r_bubble;

  assign w_in_pl = '{
    mem_r_en: in_mem_r_en,
    mem_w_en: in_mem_w_en,
    wb_en:    in_wb_en,
    exe_cmd:  in_exe_cmd,
    dest:     in_dest,
    src1:     in_src1,
    src2:     in_src2,
    val1:     in_val1,
    val2:     in_val2,
    st_value: in_st_value
  };

  pipe_skid_buf #(
    .W    (PW),
    .SKID (SKID)
  ) u_buf (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_flush     (flush),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (w_in_pl),
    .o_out_valid (w_out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (w_out_flat)
  );

  assign w_out_pl = payload_t'(w_out_flat);

  assign out_valid    = w_out_valid;
  assign out_mem_r_en = w_out_valid & w_out_pl.mem_r_en;
  assign out_mem_w_en = w_out_valid & w_out_pl.mem_w_en;
  assign out_wb_en    = w_out_valid & w_out_pl.wb_en;
  assign out_exe_cmd  = w_out_pl.exe_cmd;
  assign out_dest     = w_out_pl.dest;
  assign out_src1     = w_out_pl.src1;
  assign out_src2     = w_out_pl.src2;
  assign out_val1     = w_out_pl.val1;
  assign out_val2     = w_out_pl.val2;
  assign out_st_value = w_out_pl.st_value;

  // Flush does not clear the counter; only reset does.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble <= '0;
    end else if (!w_out_valid && (r_bubble != '1)) begin
      r_bubble <= r_bubble + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble;

endmodule

// File: tb/tb_id_ex_stage_skid.sv
// Bench for id_ex_stage_skid: SKID=1/CNT_W=4 instance with a payload
// scoreboard, plus a SKID=0 instance for the combinational-ready build.
module tb_id_ex_stage_skid;

  typedef struct packed {
    logic        mr;
    logic        mw;
    logic        wb;
    logic [3:0]  cmd;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st;
  } pl_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  logic        in_valid, in_ready;
  logic        in_mem_r_en, in_mem_w_en, in_wb_en;
  logic [3:0]  in_exe_cmd;
  logic [4:0]  in_dest, in_src1, in_src2;
  logic [31:0] in_val1, in_val2, in_st_value;
  logic        out_valid, out_ready;
  logic        out_mem_r_en, out_mem_w_en, out_wb_en;
  logic [3:0]  out_exe_cmd;
  logic [4:0]  out_dest, out_src1, out_src2;
  logic [31:0] out_val1, out_val2, out_st_value;
  logic [3:0]  bubble_cnt;

  logic        b_in_valid, b_in_ready;
  logic [31:0] b_in_val1;
  logic        b_out_valid, b_out_ready;
  logic        b_out_mem_r_en, b_out_mem_w_en, b_out_wb_en;
  logic [3:0]  b_out_exe_cmd;
  logic [4:0]  b_out_dest, b_out_src1, b_out_src2;
  logic [31:0] b_out_val1, b_out_val2, b_out_st_value;
  logic [15:0] b_bubble_cnt;

  int  n_checks = 0;
  int  n_errors = 0;
  pl_t sb_q[$];
  pl_t exp_pl;

  always #5 clk = ~clk;

  id_ex_stage_skid #(.SKID(1'b1), .CNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_r_en(in_mem_r_en), .in_mem_w_en(in_mem_w_en),
    .in_wb_en(in_wb_en), .in_exe_cmd(in_exe_cmd),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2),
    .in_val1(in_val1), .in_val2(in_val2), .in_st_value(in_st_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mem_r_en(out_mem_r_en), .out_mem_w_en(out_mem_w_en),
    .out_wb_en(out_wb_en), .out_exe_cmd(out_exe_cmd),
    .out_dest(out_dest), .out_src1(out_src1), .out_src2(out_src2),
    .out_val1(out_val1), .out_val2(out_val2),
    .out_st_value(out_st_value), .bubble_cnt(bubble_cnt)
  );

  id_ex_stage_skid #(.SKID(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_mem_r_en(1'b0), .in_mem_w_en(1'b0),
    .in_wb_en(1'b1), .in_exe_cmd(4'd2),
    .in_dest(5'd7), .in_src1(5'd1), .in_src2(5'd2),
    .in_val1(b_in_val1), .in_val2(32'd0), .in_st_value(32'd0),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_mem_r_en(b_out_mem_r_en), .out_mem_w_en(b_out_mem_w_en),
    .out_wb_en(b_out_wb_en), .out_exe_cmd(b_out_exe_cmd),
    .out_dest(b_out_dest), .out_src1(b_out_src1), .out_src2(b_out_src2),
    .out_val1(b_out_val1), .out_val2(b_out_val2),
    .out_st_value(b_out_st_value), .bubble_cnt(b_bubble_cnt)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic pl_t mk(input logic [4:0] d, input logic [31:0] v,
                             input logic [2:0] ctl);
    pl_t p;
    p.mr   = ctl[2];
    p.mw   = ctl[1];
    p.wb   = ctl[0];
    p.cmd  = d[3:0];
    p.dest = d;
    p.src1 = d + 5'd1;
    p.src2 = d + 5'd2;
    p.val1 = v;
    p.val2 = ~v;
    p.st   = v ^ 32'h5a5a_5a5a;
    return p;
  endfunction

  task automatic drive(input pl_t p, input logic v);
    in_mem_r_en = p.mr;
    in_mem_w_en = p.mw;
    in_wb_en    = p.wb;
    in_exe_cmd  = p.cmd;
    in_dest     = p.dest;
    in_src1     = p.src1;
    in_src2     = p.src2;
    in_val1     = p.val1;
    in_val2     = p.val2;
    in_st_value = p.st;
    in_valid    = v;
  endtask

  function automatic pl_t cur_in();
    return {in_mem_r_en, in_mem_w_en, in_wb_en, in_exe_cmd, in_dest,
            in_src1, in_src2, in_val1, in_val2, in_st_value};
  endfunction

  function automatic pl_t cur_out();
    return {out_mem_r_en, out_mem_w_en, out_wb_en, out_exe_cmd, out_dest,
            out_src1, out_src2, out_val1, out_val2, out_st_value};
  endfunction

  // Monitor: sampled mid-cycle, mirrors the handshake that the next edge commits.
  always @(negedge clk) begin
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got dest %0d val1 %0h expected none",
                   out_dest, out_val1);
        end else begin
          exp_pl = sb_q.pop_front();
          chk("sb_payload", cur_out(), exp_pl);
        end
      end
      if (!out_valid) begin
        chk("ctl_gating", {out_mem_r_en, out_mem_w_en, out_wb_en}, 3'b000);
      end
      if (in_valid && in_ready) begin
        sb_q.push_back(cur_in());
      end
    end
  end

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    drive('0, 1'b0);
    b_in_valid = 1'b0;
    b_in_val1 = 32'd0;
    b_out_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_payload", cur_out(), '0);
    chk("rst_bubble", bubble_cnt, 4'd0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);

    // Bubble counter saturates and survives flush
    repeat (20) step();
    @(negedge clk);
    chk("bubble_sat", bubble_cnt, 4'd15);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("bubble_flush", bubble_cnt, 4'd15);

    // Streaming
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      drive(mk(5'(i + 1), 32'(i), {i[0], 1'b0, 1'b1}), 1'b1);
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      if (i > 0) begin
        chk("stream_out_valid", out_valid, 1'b1);
        chk("stream_val1", out_val1, 32'(i - 1));
      end
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_last_valid", out_valid, 1'b1);
    chk("stream_last_val1", out_val1, 32'd7);
    step();
    @(negedge clk);
    chk("stream_drained", out_valid, 1'b0);

    // Back-pressure into FULL
    step();
    out_ready = 1'b0;
    drive(mk(5'd3, 32'hA, 3'b001), 1'b1);
    @(negedge clk);
    chk("bp_ready_a", in_ready, 1'b1);
    step();
    drive(mk(5'd4, 32'hB, 3'b100), 1'b1);
    @(negedge clk);
    chk("bp_ready_b", in_ready, 1'b1);
    chk("bp_head_a", out_dest, 5'd3);
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_full_ready", in_ready, 1'b0);
    chk("bp_full_head", out_dest, 5'd3);
    step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_rel_head", out_dest, 5'd3);
    chk("bp_rel_ready", in_ready, 1'b0);
    step();
    @(negedge clk);
    chk("bp_b_head", out_dest, 5'd4);
    chk("bp_ready_back", in_ready, 1'b1);
    step();
    @(negedge clk);
    chk("bp_empty", out_valid, 1'b0);

    // Flush in FULL with C offered
    step();
    out_ready = 1'b0;
    drive(mk(5'd5, 32'h55, 3'b111), 1'b1);
    step();
    drive(mk(5'd6, 32'h66, 3'b111), 1'b1);
    step();
    drive(mk(5'd9, 32'h99, 3'b111), 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_full_ready", in_ready, 1'b0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_out_valid", out_valid, 1'b0);
    chk("fl_wb_en", out_wb_en, 1'b0);
    chk("fl_mem_w_en", out_mem_w_en, 1'b0);
    chk("fl_in_ready", in_ready, 1'b1);

    // Flush in ONE with E offered and accepted-looking
    step();
    out_ready = 1'b0;
    drive(mk(5'd10, 32'h1010, 3'b011), 1'b1);
    step();
    drive(mk(5'd11, 32'h1111, 3'b011), 1'b1);
    flush = 1'b1;
    @(negedge clk);
    chk("fl_one_ready", in_ready, 1'b1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_one_valid", out_valid, 1'b0);
    repeat (3) step();

    // SKID=0 build
    step();
    b_in_valid = 1'b1;
    b_in_val1 = 32'h11;
    @(negedge clk);
    chk("s0_ready_empty", b_in_ready, 1'b1);
    step();
    b_in_val1 = 32'h22;
    @(negedge clk);
    chk("s0_ready_stall", b_in_ready, 1'b0);
    chk("s0_head_11", b_out_val1, 32'h11);
    step();
    b_out_ready = 1'b1;
    @(negedge clk);
    chk("s0_ready_comb", b_in_ready, 1'b1);
    step();
    b_in_valid = 1'b0;
    @(negedge clk);
    chk("s0_valid_22", b_out_valid, 1'b1);
    chk("s0_head_22", b_out_val1, 32'h22);
    step();
    @(negedge clk);
    chk("s0_drained", b_out_valid, 1'b0);

    // Reset and flush together mid-transfer
    step();
    out_ready = 1'b0;
    drive(mk(5'd12, 32'hC0, 3'b111), 1'b1);
    step();
    drive(mk(5'd13, 32'hD0, 3'b111), 1'b1);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("rf_out_valid", out_valid, 1'b0);
    chk("rf_in_ready", in_ready, 1'b1);
    chk("rf_bubble", bubble_cnt, 4'd0);
    chk("rf_payload", cur_out(), '0);
    out_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("sb_leftover", 128'(sb_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
